// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two character requesters, the arbiter and UART_TX.
// slave = arbiter side, master = requester/UART side.
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req0_data;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req0_ready;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_valid;
    logic                  tx_busy;
    logic [1:0]            grant;
    logic                  timeout_err;

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_data, tx_data_valid, grant, timeout_err
    );

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_data, tx_data_valid, grant, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART_TX from two requesters; rst is async active-low.
// Optional macro UART_ARB_BURST_EN lets an owner send up to BURST_LEN characters per grant.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16,
    parameter int BURST_LEN    = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int unsigned   TCW     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TCW-1:0] TO_MAX  = TCW'(BUSY_TIMEOUT);
    localparam logic [TCW-1:0] TO_LAST = TCW'(BUSY_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;      // 1: req1 owned the previous grant
    logic                  rdy0_q, rdy0_d;
    logic                  rdy1_q, rdy1_d;
    logic                  txv_q;
    logic                  err_q, err_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic                  pick1;

`ifdef UART_ARB_BURST_EN
    localparam int unsigned   BCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           own_valid;
`endif

    // req1 wins when it is the only requester, or when both ask and req0 owned last.
    assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_q);

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rdy0_d    = 1'b0;
        rdy1_d    = 1'b0;
        err_d     = err_q;
        tcnt_d    = tcnt_q;
`ifdef UART_ARB_BURST_EN
        bcnt_d    = bcnt_q;
        own_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && (bus.req0_valid || bus.req1_valid)) begin
                    state_d   = LAUNCH;
                    grant_d   = pick1 ? 2'b10 : 2'b01;
                    last_d    = pick1;
                    tx_data_d = pick1 ? bus.req1_data : bus.req0_data;
                    rdy0_d    = !pick1;
                    rdy1_d    = pick1;
`ifdef UART_ARB_BURST_EN
                    bcnt_d    = '0;
`endif
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                tcnt_d  = '0;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    if (tcnt_q != TO_MAX) tcnt_d = tcnt_q + TCW'(1);
                    if (tcnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
`ifdef UART_ARB_BURST_EN
                    if (own_valid && (bcnt_q != BURST_LAST)) begin
                        state_d   = LAUNCH;
                        bcnt_d    = bcnt_q + BCW'(1);
                        tx_data_d = grant_q[1] ? bus.req1_data : bus.req0_data;
                        rdy0_d    = grant_q[0];
                        rdy1_d    = grant_q[1];
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
`else
                    state_d = IDLE;
                    grant_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            grant_q   <= '0;
            last_q    <= 1'b1;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            txv_q     <= 1'b0;
            err_q     <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            rdy0_q    <= rdy0_d;
            rdy1_q    <= rdy1_d;
            txv_q     <= (state_q == LAUNCH);
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
        end
    end

`ifdef UART_ARB_BURST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bcnt_q <= '0;
        else      bcnt_q <= bcnt_d;
    end
`endif

    assign bus.req0_ready    = rdy0_q;
    assign bus.req1_ready    = rdy1_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = txv_q;
    assign bus.grant         = grant_q;
    assign bus.timeout_err   = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; launched characters are checked against a scoreboard queue.
module tb_uart_tx_arbiter;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic man_busy = 1'b0;
    logic auto_en  = 1'b0;
    int   resp_cnt = 0;

    uart_tx_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .DATA_WIDTH  (DW),
        .BUSY_TIMEOUT(16),
        .BURST_LEN   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // UART_TX stand-in: busy for 3 cycles starting one cycle after each strobe.
    always @(posedge clk) begin
        if (auto_en && bus.tx_data_valid) resp_cnt <= 3;
        else if (resp_cnt != 0)           resp_cnt <= resp_cnt - 1;
    end
    assign bus.tx_busy = man_busy | (resp_cnt != 0);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    grant;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [1:0] g);
        exp_t e;
        e.data  = d;
        e.grant = g;
        sb.push_back(e);
    endtask

    // One clock step; samples 1 time unit after the edge and scores any launch.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.tx_data_valid) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_launch: observed tx_data 0x%0h expected no launch", bus.tx_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_tx_data", 32'(bus.tx_data), 32'(e.data));
                check("sb_grant", 32'(bus.grant), 32'(e.grant));
            end
        end
        if (bus.req0_ready || bus.req1_ready)
            check("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    endtask

    task automatic wait_ready(input int max);
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus.req0_ready || bus.req1_ready) break;
        end
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int seen;

        rst            = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        repeat (3) tick();

        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_data_valid), 32'd0);
        check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Both requesters held valid continuously.
        auto_en       = 1'b1;
        bus.req0_data = 8'h11;
        bus.req1_data = 8'h22;
`ifdef UART_ARB_BURST_EN
        n = 8;
        for (int i = 0; i < 4; i++) push(8'h11, 2'b01);
        for (int i = 0; i < 4; i++) push(8'h22, 2'b10);
`else
        n = 4;
        for (int i = 0; i < 2; i++) begin
            push(8'h11, 2'b01);
            push(8'h22, 2'b10);
        end
`endif
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 400 && seen < n; i++) begin
            tick();
            if (bus.req0_ready || bus.req1_ready) seen++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("stream_ready_count", 32'(seen), 32'(n));
        drain(100);
        repeat (6) tick();

        // Single character 0xA5 from req0, cycle-exact.
        auto_en        = 1'b0;
        push(8'hA5, 2'b01);
        bus.req0_data  = 8'hA5;
        bus.req0_valid = 1'b1;
        tick();
        check("a5_ready0_c1", 32'(bus.req0_ready), 32'd1);
        check("a5_ready1_c1", 32'(bus.req1_ready), 32'd0);
        check("a5_valid_c1", 32'(bus.tx_data_valid), 32'd0);
        check("a5_grant_c1", 32'(bus.grant), 32'd1);
        bus.req0_valid = 1'b0;
        tick();
        check("a5_valid_c2", 32'(bus.tx_data_valid), 32'd1);
        check("a5_ready0_c2", 32'(bus.req0_ready), 32'd0);
        tick();
        check("a5_valid_c3", 32'(bus.tx_data_valid), 32'd0);
        man_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a5_grant_busy", 32'(bus.grant), 32'd1);
            check("a5_tx_data_hold", 32'(bus.tx_data), 32'hA5);
        end
        man_busy = 1'b0;
        tick();
        check("a5_grant_release", 32'(bus.grant), 32'd0);
        repeat (2) tick();

        // UART never raises busy: timeout after 16 cycles in WAIT_BUSY.
        push(8'h3C, 2'b10);
        bus.req1_data  = 8'h3C;
        bus.req1_valid = 1'b1;
        tick();
        check("to_ready1", 32'(bus.req1_ready), 32'd1);
        bus.req1_valid = 1'b0;
        tick();
        check("to_valid", 32'(bus.tx_data_valid), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("to_err_early", 32'(bus.timeout_err), 32'd0);
        check("to_grant_waiting", 32'(bus.grant), 32'd2);
        tick();
        check("to_err_set", 32'(bus.timeout_err), 32'd1);
        check("to_grant_idle", 32'(bus.grant), 32'd0);
        auto_en = 1'b1;
        push(8'h5A, 2'b01);
        bus.req0_data  = 8'h5A;
        bus.req0_valid = 1'b1;
        wait_ready(20);
        check("to_recover_ready0", 32'(bus.req0_ready), 32'd1);
        bus.req0_valid = 1'b0;
        drain(50);
        repeat (6) tick();
        check("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        // Reset asserted during WAIT_DONE.
        auto_en = 1'b0;
        push(8'h77, 2'b01);
        bus.req0_data  = 8'h77;
        bus.req0_valid = 1'b1;
        wait_ready(10);
        check("rmid_ready0", 32'(bus.req0_ready), 32'd1);
        bus.req0_valid = 1'b0;
        tick();
        man_busy = 1'b1;
        tick();
        tick();
        check("rmid_grant_pre", 32'(bus.grant), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rmid_tx_data", 32'(bus.tx_data), 32'd0);
        check("rmid_tx_valid", 32'(bus.tx_data_valid), 32'd0);
        check("rmid_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("rmid_grant", 32'(bus.grant), 32'd0);
        check("rmid_timeout_err", 32'(bus.timeout_err), 32'd0);
        man_busy = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rpost_quiet", 32'({bus.req0_ready, bus.req1_ready, bus.tx_data_valid}), 32'd0);
        end

        // Busy already high in IDLE blocks arbitration; a dropped req0 is never served.
        auto_en        = 1'b1;
        man_busy       = 1'b1;
        push(8'h99, 2'b10);
        bus.req1_data  = 8'h99;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h44;
        bus.req0_valid = 1'b1;
        tick();
        check("blk_no_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blk_no_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        man_busy = 1'b0;
        tick();
        check("blk_ready1", 32'(bus.req1_ready), 32'd1);
        check("blk_ready0", 32'(bus.req0_ready), 32'd0);
        check("blk_grant", 32'(bus.grant), 32'd2);
        bus.req1_valid = 1'b0;
        drain(50);
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width of one UART character.
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 16, the number of clk cycles to wait for tx_busy to rise after a launch.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, the maximum consecutive characters per grant; used only when the burst feature is compiled in.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock (UART_TX clock domain).
REQ-005 The block SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each, requester has a character pending.
REQ-007 The block SHALL have ports req0_data / req1_data, input, DATA_WIDTH each, the requester character.
REQ-008 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each, a 1-cycle pulse that accepts the requester character.
REQ-009 The block SHALL have port tx_data, output, DATA_WIDTH, the character driven to UART_TX.
REQ-010 The block SHALL have port tx_data_valid, output, 1 bit, a 1-cycle launch strobe to UART_TX.
REQ-011 The block SHALL have port tx_busy, input, 1 bit, UART_TX frame in progress.
REQ-012 The block SHALL have port grant, output, 2 bits, one-hot current owner (00 = none).
REQ-013 The block SHALL have port timeout_err, output, 1 bit, a sticky flag set when tx_busy fails to rise.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with any reqN_valid high, the FSM SHALL select an owner round-robin, starting from the requester after the last owner (req0 first after reset), and register its data into tx_data.
REQ-016 IDLE SHALL go to LAUNCH, and reqN_ready for the owner SHALL pulse in that same cycle.
REQ-017 LAUNCH SHALL assert tx_data_valid for exactly one cycle, then go to WAIT_BUSY.
REQ-018 WAIT_BUSY SHALL go to WAIT_DONE on tx_busy=1.
REQ-019 If tx_busy stays 0 for BUSY_TIMEOUT cycles in WAIT_BUSY, the block SHALL set timeout_err and return to IDLE with the character dropped.
REQ-020 WAIT_DONE SHALL return to IDLE on tx_busy=0.
REQ-021 Latency from reqN_valid rising (FSM in IDLE, tx_busy=0) to tx_data_valid SHALL be 2 cycles.
REQ-022 tx_data SHALL be held stable from LAUNCH until the FSM leaves WAIT_DONE.
REQ-023 grant SHALL be one-hot from LAUNCH through WAIT_DONE and 00 in IDLE.
REQ-024 When both requesters are valid in the same cycle, the non-last-owner SHALL win; the loser SHALL see no ready pulse.
REQ-025 A requester dropping valid while not granted SHALL not be served.
REQ-026 tx_busy already high while in IDLE SHALL block arbitration until it falls.
REQ-027 The timeout counter SHALL saturate at BUSY_TIMEOUT and clear on each entry to WAIT_BUSY.
REQ-028 At most one reqN_ready SHALL be high in any cycle.

Reset
REQ-029 On rst=0 the block SHALL immediately force state IDLE, tx_data=0, tx_data_valid=0, req0_ready=0, req1_ready=0, grant=00, timeout_err=0, last owner=req1 and counters=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no ready or valid pulse after release.
REQ-031 timeout_err SHALL clear only on reset.

Configuration
REQ-032 With UART_ARB_BURST_EN defined, on leaving WAIT_DONE with the owner still valid and fewer than BURST_LEN characters sent this grant, the FSM SHALL go directly to the next LAUNCH for the same owner, with ready pulsed on the transition cycle, ignoring the other requester.
REQ-033 The burst counter SHALL reset to 0 on each new grant.
REQ-034 Without UART_ARB_BURST_EN, ownership SHALL always return to IDLE and re-arbitrate after every character, and BURST_LEN SHALL be unused.

Verification
REQ-035 The bench SHALL cover: req0_valid with data 0xA5, tx_busy rising 1 cycle after the strobe and held 10 cycles -> req0_ready at cycle 1, tx_data_valid at cycle 2 with tx_data=0xA5, grant=01 until tx_busy falls.
REQ-036 The bench SHALL cover: both requesters valid continuously with data 0x11 / 0x22, burst off -> order 0x11, 0x22, 0x11, 0x22.
REQ-037 The bench SHALL cover: tx_busy held 0 after the strobe -> timeout_err=1 exactly 16 cycles after entry to WAIT_BUSY, FSM in IDLE, next request served normally.
REQ-038 The bench SHALL cover: UART_ARB_BURST_EN, BURST_LEN=4, both valid -> 4 characters from req0 then 4 from req1.
REQ-039 The bench SHALL cover: rst=0 asserted during WAIT_DONE -> all outputs 0 at once, no ready/valid pulse for 3 cycles after release with no requests.
REQ-040 The bench SHALL cover: tx_busy=1 in IDLE while req1_valid=1 -> no ready until tx_busy=0, then ready 1 cycle later.
